// File: rtl/wptr_full.sv
// Write-domain pointer/full controller for a 2^ADDRSIZE-deep dual-clock FIFO.
// Synchronises the Gray read pointer and produces full, almost-full, fill level and overflow.
module wptr_full #(
    parameter int ADDRSIZE     = 9,
    parameter int AFULL_THRESH = 496
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic                wovf_clr,
    output logic                wclken,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);
    localparam int PW = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] AFULL_C = PW'(AFULL_THRESH);

    function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDRSIZE:0] wbin_q,     wbin_d;
    logic [ADDRSIZE:0] wptr_q,     wptr_d;
    logic [ADDRSIZE:0] wq1_rptr_q;
    logic [ADDRSIZE:0] wq2_rptr_q;
    logic [ADDRSIZE:0] wlevel_q,   wlevel_d;
    logic              wfull_q,    wfull_d;
    logic              wafull_q,   wafull_d;
    logic              wovf_q,     wovf_d;
    logic [ADDRSIZE:0] wq2_rbin_s;
    logic              wclken_s;

    assign wclken_s = winc & ~wfull_q;

    // Next-state: pointer advance, full/level against the synchronised read pointer, overflow.
    always_comb begin
        wbin_d     = wbin_q + {{ADDRSIZE{1'b0}}, wclken_s};
        wptr_d     = bin2gray(wbin_d);
        wq2_rbin_s = gray2bin(wq2_rptr_q);
        wlevel_d   = wbin_d - wq2_rbin_s;
        // Full when the write pointer is one lap (MSB and next bit inverted in Gray) ahead.
        wfull_d    = (wptr_d == {~wq2_rptr_q[ADDRSIZE:ADDRSIZE-1], wq2_rptr_q[ADDRSIZE-2:0]});
        wafull_d   = (wlevel_d >= AFULL_C);
        if (winc && wfull_q) begin
            wovf_d = 1'b1;
        end else if (wovf_clr) begin
            wovf_d = 1'b0;
        end else begin
            wovf_d = wovf_q;
        end
    end

    // State registers, including the two-stage read-pointer synchroniser.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q     <= '0;
            wptr_q     <= '0;
            wq1_rptr_q <= '0;
            wq2_rptr_q <= '0;
            wlevel_q   <= '0;
            wfull_q    <= 1'b0;
            wafull_q   <= 1'b0;
            wovf_q     <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wptr_q     <= wptr_d;
            wq1_rptr_q <= rptr;
            wq2_rptr_q <= wq1_rptr_q;
            wlevel_q   <= wlevel_d;
            wfull_q    <= wfull_d;
            wafull_q   <= wafull_d;
            wovf_q     <= wovf_d;
        end
    end

    assign wclken       = wclken_s;
    assign waddr        = wbin_q[ADDRSIZE-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign wlevel       = wlevel_q;
    assign wovf         = wovf_q;

endmodule
